// File: rtl/alu_result_stage_pkg.sv
// Shared ALU opcode encodings, stage widths and the trapping-opcode membership test.
// Opcode macros are global so decode, execute and this stage agree on one encoding.
`ifndef ALU_OPCODES_DEFINED
`define ALU_OPCODES_DEFINED
`define ADD  4'h0
`define SUB  4'h1
`define ADDU 4'h2
`define SUBU 4'h3
`define NEG  4'h4
`define AND  4'h5
`define OR   4'h6
`define XOR  4'h7
`define SLL  4'h8
`define SRL  4'h9
`define SRA  4'ha
`define SLT  4'hb
`endif

package alu_result_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;
  localparam int OP_W_DEF   = 4;
  localparam int CNT_W_DEF  = 8;

  typedef logic [OP_W_DEF-1:0] op_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Only the signed arithmetic ops can raise an overflow trap.
  function automatic logic is_trap_op(input op_t op);
    return (op == `ADD) || (op == `SUB) || (op == `NEG);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-result handshake bundle: upstream result/flags in, registered head entry out.
interface alu_result_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int OP_W   = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_negative;
  logic [OP_W-1:0]   in_op;
  logic [RD_W-1:0]   in_rd;
  logic              in_wen;
  logic              in_trap_en;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_overflow;
  logic              out_negative;
  logic [RD_W-1:0]   out_rd;
  logic              out_wen;

  modport master (
    output in_valid, alu_out, alu_zero, alu_overflow, alu_negative,
           in_op, in_rd, in_wen, in_trap_en, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_overflow,
           out_negative, out_rd, out_wen
  );

  modport slave (
    input  in_valid, alu_out, alu_zero, alu_overflow, alu_negative,
           in_op, in_rd, in_wen, in_trap_en, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_overflow,
           out_negative, out_rd, out_wen
  );
endinterface

// File: rtl/result_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer; 1-cycle latency, order preserved.
// in_ready is a pure register (low only while the skid entry holds data); flush empties it.
module result_skid_buffer
  import alu_result_stage_pkg::*;
#(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_dat
);

  skid_state_t  state;
  logic [W-1:0] skid_dat;
  logic         accept;
  logic         pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SKID_EMPTY;
      out_dat   <= '0;
      skid_dat  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (flush) begin
      state     <= SKID_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        SKID_EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            out_dat   <= in_dat;
            out_valid <= 1'b1;
            state     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && !pop) begin
            skid_dat <= in_dat;
            in_ready <= 1'b0;
            state    <= SKID_FULL;
          end else if (pop && !accept) begin
            out_valid <= 1'b0;
            state     <= SKID_EMPTY;
          end else if (accept && pop) begin
            out_dat <= in_dat;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            out_dat  <= skid_dat;
            in_ready <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        default: begin
          state     <= SKID_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// EX->MEM result register: skid-buffers ALU result/flags/rd and applies the overflow trap policy.
// 1-cycle latency; in_ready comes from registers only; traps kill the write and log a sticky record.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_stage_if.slave io,
  input  logic              flush,
  output logic              exc_pending,
  output logic [OP_W-1:0]   exc_op,
  output logic [DATA_W-1:0] exc_result,
  input  logic              exc_clear,
  output logic [CNT_W-1:0]  trap_count
);

  localparam int PW = DATA_W + 3 + RD_W + 1;

  logic          trap;
  logic          trap_taken;
  logic [PW-1:0] in_dat;
  logic [PW-1:0] out_dat;

  assign trap       = io.in_trap_en & io.alu_overflow & is_trap_op(io.in_op);
  // A flushed accept never happened, so it must not leave a trap behind.
  assign trap_taken = io.in_valid & io.in_ready & trap & ~flush;

  assign in_dat = {io.alu_out, io.alu_zero, io.alu_overflow, io.alu_negative,
                   io.in_rd, io.in_wen & ~trap};

  assign {io.out_result, io.out_zero, io.out_overflow, io.out_negative,
          io.out_rd, io.out_wen} = out_dat;

  result_skid_buffer #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (io.in_valid),
    .in_ready  (io.in_ready),
    .in_dat    (in_dat),
    .out_valid (io.out_valid),
    .out_ready (io.out_ready),
    .out_dat   (out_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_pending <= 1'b0;
      exc_op      <= '0;
      exc_result  <= '0;
      trap_count  <= '0;
    end else begin
      // A clear in the same cycle as a new trap lets the new trap replace the record.
      if (trap_taken && (!exc_pending || exc_clear)) begin
        exc_pending <= 1'b1;
        exc_op      <= io.in_op;
        exc_result  <= io.alu_out;
      end else if (exc_clear) begin
        exc_pending <= 1'b0;
      end
      if (trap_taken && (trap_count != {CNT_W{1'b1}})) begin
        trap_count <= trap_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a scoreboard of expected output beats.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        exc_clear = 1'b0;
  logic        exc_pending;
  logic [3:0]  exc_op;
  logic [31:0] exc_result;
  logic [7:0]  trap_count;

  int errors = 0;
  int checks = 0;

  logic [40:0] sb[$];

  logic        m_pend = 1'b0;
  logic [3:0]  m_op = 4'h0;
  logic [31:0] m_res = 32'h0;
  logic [7:0]  m_cnt = 8'h0;

  alu_result_stage_if #(.DATA_W(32), .RD_W(5), .OP_W(4)) io ();

  alu_result_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io          (io),
    .flush       (flush),
    .exc_pending (exc_pending),
    .exc_op      (exc_op),
    .exc_result  (exc_result),
    .exc_clear   (exc_clear),
    .trap_count  (trap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every handshaken pop is matched against the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        chk("pop_without_expected", 64'd1, 64'd0);
      end else begin
        chk("out_beat", {io.out_result, io.out_zero, io.out_overflow, io.out_negative,
                         io.out_rd, io.out_wen}, sb.pop_front());
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic [3:0] op, input logic [4:0] rd,
                       input logic wen, input logic ovf, input logic ten);
    io.in_valid     = 1'b1;
    io.alu_out      = d;
    io.alu_zero     = (d == 32'h0);
    io.alu_negative = d[31];
    io.alu_overflow = ovf;
    io.in_op        = op;
    io.in_rd        = rd;
    io.in_wen       = wen;
    io.in_trap_en   = ten;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] op, input logic [4:0] rd,
                      input logic wen, input logic ovf, input logic ten);
    logic trap;
    bit   done;
    trap = ten && ovf && (op == 4'h0 || op == 4'h1 || op == 4'h4);
    done = 1'b0;
    drive(d, op, rd, wen, ovf, ten);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (io.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      sb.push_back({d, (d == 32'h0), ovf, d[31], rd, wen && !trap});
      if (trap) begin
        if (!m_pend || exc_clear) begin
          m_pend = 1'b1;
          m_op   = op;
          m_res  = d;
        end
        if (m_cnt != 8'hff) m_cnt = m_cnt + 8'h1;
      end else if (exc_clear) begin
        m_pend = 1'b0;
      end
    end
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic chk_exc(input string tag);
    chk({tag, "_pend"}, exc_pending, m_pend);
    chk({tag, "_cnt"}, trap_count, m_cnt);
    if (m_pend) begin
      chk({tag, "_op"}, exc_op, m_op);
      chk({tag, "_res"}, exc_result, m_res);
    end
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    drive(32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    io.in_valid = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", io.in_ready, 0);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_result", io.out_result, 0);
    chk("rst_exc_pending", exc_pending, 0);
    chk("rst_trap_count", trap_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", io.in_ready, 1);

    // Single transfer, then back to empty
    io.out_ready = 1'b1;
    send(32'h5, `ADD, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("single_out_valid", io.out_valid, 1);
    chk("single_out_rd", io.out_rd, 3);
    drain();
    @(posedge clk); #1;
    chk("single_empty", io.out_valid, 0);

    // Backpressure: third beat held until downstream drains
    io.out_ready = 1'b0;
    send(32'h1, `ADDU, 5'd1, 1'b1, 1'b0, 1'b0);
    send(32'h2, `ADDU, 5'd2, 1'b1, 1'b0, 1'b0);
    chk("bp_in_ready_low", io.in_ready, 0);
    fork
      send(32'h3, `ADDU, 5'd3, 1'b1, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_still_full", io.in_ready, 0);
        chk("bp_head_held", io.out_result, 32'h1);
        io.out_ready = 1'b1;
      end
    join
    drain();

    // Trap on ADD, no trap on ADDU overflow
    send(32'h8000_0000, `ADD, 5'd7, 1'b1, 1'b1, 1'b1);
    chk_exc("trap_add");
    send(32'h8000_0001, `ADDU, 5'd8, 1'b1, 1'b1, 1'b1);
    chk_exc("addu_no_trap");
    drain();

    // First trap wins; clear coinciding with a new trap records the new one
    exc_clear = 1'b1;
    @(posedge clk); #1;
    exc_clear = 1'b0;
    m_pend = 1'b0;
    chk_exc("cleared");
    send(32'h7fff_fff0, `SUB, 5'd9, 1'b1, 1'b1, 1'b1);
    send(32'h8000_0000, `NEG, 5'd10, 1'b1, 1'b1, 1'b1);
    chk_exc("first_wins");
    exc_clear = 1'b1;
    send(32'h0, `ADD, 5'd11, 1'b1, 1'b1, 1'b1);
    exc_clear = 1'b0;
    chk_exc("clear_and_trap");
    drain();

    // Flush in FULL with an offered trapping beat
    io.out_ready = 1'b0;
    send(32'h11, `AND, 5'd1, 1'b1, 1'b0, 1'b0);
    send(32'h22, `OR, 5'd2, 1'b1, 1'b0, 1'b0);
    drive(32'h8000_0000, `ADD, 5'd3, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    io.in_valid = 1'b0;
    sb.delete();
    chk("flush_full_out_valid", io.out_valid, 0);
    chk("flush_full_in_ready", io.in_ready, 1);
    chk_exc("flush_full");

    // Flush in ONE discards a same-cycle trapping accept
    exc_clear = 1'b1;
    @(posedge clk); #1;
    exc_clear = 1'b0;
    m_pend = 1'b0;
    send(32'h33, `XOR, 5'd4, 1'b1, 1'b0, 1'b0);
    drive(32'h8000_0000, `SUB, 5'd5, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    io.in_valid = 1'b0;
    sb.delete();
    chk("flush_one_out_valid", io.out_valid, 0);
    chk_exc("flush_one");

    // Asynchronous reset between edges while FULL
    send(32'h44, `AND, 5'd6, 1'b1, 1'b0, 1'b0);
    send(32'h55, `AND, 5'd7, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", io.out_valid, 0);
    chk("async_out_result", io.out_result, 0);
    chk("async_in_ready", io.in_ready, 0);
    chk("async_trap_count", trap_count, 0);
    chk("async_exc_pending", exc_pending, 0);
    sb.delete();
    m_pend = 1'b0;
    m_cnt  = 8'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Saturating trap counter
    io.out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send(32'h8000_0000 + i, `ADD, 5'(i), 1'b1, 1'b1, 1'b1);
      if (i == 254 || i == 259) chk("sat_trap_count", trap_count, m_cnt);
    end
    chk("sat_value", trap_count, 8'hff);
    chk_exc("sat_record");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
